// File: rtl/hndshk_pkg.sv
// Shared types and defaults for the handshake destination buffer.
// Holds the occupancy-state enum, default geometry and a level-to-state helper.
package hndshk_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

  function automatic occ_state_t occ_state_of(input int lvl, input int depth);
    if (lvl == 0)          return OCC_EMPTY;
    else if (lvl >= depth) return OCC_FULL;
    else                   return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/hndshk_dest_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, asynchronous read.
module hndshk_dest_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers
  // and level, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hndshk_dest_buffer.sv
// First-word fall-through buffer behind a handshake destination, with registered stall.
// Optional accept_count statistics output enabled by macro HNDSHK_DEST_STATS_EN.
module hndshk_dest_buffer
  import hndshk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   dest_clk,
  input  logic                   dest_reset_n,
  input  logic                   dest_strobe,
  input  logic [DATA_W-1:0]      dest_data,
  output logic                   dest_stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef HNDSHK_DEST_STATS_EN
  ,
  output logic [15:0]            accept_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_STALL = LW'(DEPTH - 1);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic [LW-1:0]     level_nxt;
  occ_state_t        state;
  logic              push, pop, drop;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = dest_strobe && ((level != LVL_FULL) || pop);
    drop      = dest_strobe && (level == LVL_FULL) && !pop;
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n) begin
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= OCC_EMPTY;
      dest_stall <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      level      <= level_nxt;
      state      <= occ_state_of(int'(level_nxt), DEPTH);
      dest_stall <= (level_nxt >= LVL_STALL);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign out_valid = (state != OCC_EMPTY);
  // Gated so the unreset array never leaks stale data while empty or in reset.
  assign out_data  = out_valid ? rd_data : '0;

  hndshk_dest_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (dest_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (dest_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

`ifdef HNDSHK_DEST_STATS_EN
  always_ff @(posedge dest_clk or negedge dest_reset_n) begin
    if (!dest_reset_n)                       accept_count <= '0;
    else if (push && (accept_count != '1))   accept_count <= accept_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hndshk_dest_buffer.sv
// Directed self-checking bench for hndshk_dest_buffer (DATA_W=8, DEPTH=4).
// Honors HNDSHK_DEST_STATS_EN for the accept_count checks.
module tb_hndshk_dest_buffer;
  import hndshk_pkg::*;

  logic       dest_clk;
  logic       dest_reset_n;
  logic       dest_strobe;
  logic [7:0] dest_data;
  logic       dest_stall;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;
  logic       overflow;
`ifdef HNDSHK_DEST_STATS_EN
  logic [15:0] accept_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hndshk_dest_buffer #(.DATA_W(8), .DEPTH(4)) dut (
    .dest_clk     (dest_clk),
    .dest_reset_n (dest_reset_n),
    .dest_strobe  (dest_strobe),
    .dest_data    (dest_data),
    .dest_stall   (dest_stall),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow     (overflow)
`ifdef HNDSHK_DEST_STATS_EN
    ,
    .accept_count (accept_count)
`endif
  );

  initial dest_clk = 1'b0;
  always #5 dest_clk = ~dest_clk;

  task automatic tick();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic apply_reset();
    dest_reset_n = 1'b0;
    dest_strobe  = 1'b0;
    out_ready    = 1'b0;
    tick();
    dest_reset_n = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] d);
    dest_strobe = 1'b1;
    dest_data   = d;
    tick();
    dest_strobe = 1'b0;
  endtask

  task automatic test_reset();
    dest_reset_n = 1'b0;
    dest_strobe  = 1'b1;
    dest_data    = 8'hFF;
    out_ready    = 1'b0;
    #3;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (dest_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", dest_stall); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
    tick();
    tick();
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_strobe_ignored: level got %0d want 0", level); end
    dest_strobe  = 1'b0;
    dest_reset_n = 1'b1;
  endtask

  task automatic test_single();
    push_word(8'hA5);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", out_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_fill_overflow();
    push_word(8'h01);
    push_word(8'h02);
    n_checks++; if (dest_stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_l2: got %b want 0", dest_stall); end
    push_word(8'h03);
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL fill_level3: got %0d want 3", level); end
    n_checks++; if (dest_stall !== 1'b1) begin n_fail++; $display("FAIL fill_stall_l3: got %b want 1", dest_stall); end
    push_word(8'h04);
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level4: got %0d want 4", level); end
    n_checks++; if (dut.state !== OCC_FULL) begin n_fail++; $display("FAIL fill_state: got %0d want FULL", dut.state); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b want 0", overflow); end
    push_word(8'h05);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b want 1", overflow); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL drop_level: got %0d want 4", level); end
    n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL drop_head: got %h want 01", out_data); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (out_data !== 8'(i)) begin n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", i, out_data, 8'(i)); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_checks++; if (dest_stall !== 1'b0) begin n_fail++; $display("FAIL drain_stall: got %b want 0", dest_stall); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
    apply_reset();
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    dest_strobe = 1'b1;
    dest_data   = 8'h06;
    out_ready   = 1'b1;
    n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL fpp_popped: got %h want 01", out_data); end
    tick();
    dest_strobe = 1'b0;
    out_ready   = 1'b0;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fpp_level: got %0d want 4", level); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_data !== exp_q[i]) begin n_fail++; $display("FAIL fpp_drain[%0d]: got %h want %h", i, out_data, exp_q[i]); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL fpp_end_level: got %0d want 0", level); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dest_strobe = 1'b1;
      dest_data   = 8'h10 + 8'(i);
      tick();
      n_checks++; if (out_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(i)); end
      n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL b2b_level[%0d]: got %0d want 1", i, level); end
    end
    dest_strobe = 1'b0;
    tick();
    out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_end_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    push_word(8'h31);
    push_word(8'h32);
    push_word(8'h33);
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_level: got %0d want 3", level); end
    dest_reset_n = 1'b0;
    #1;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", level); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    n_checks++; if (dest_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall: got %b want 0", dest_stall); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", out_data); end
    #1;
    dest_reset_n = 1'b1;
    push_word(8'h7E);
    n_checks++; if (out_data !== 8'h7E) begin n_fail++; $display("FAIL rmid_first_data: got %h want 7e", out_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL rmid_first_level: got %0d want 1", level); end
`ifdef HNDSHK_DEST_STATS_EN
    n_checks++; if (accept_count !== 16'd1) begin n_fail++; $display("FAIL rmid_accept_count: got %0d want 1", accept_count); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    dest_reset_n = 1'b0;
    dest_strobe  = 1'b0;
    dest_data    = 8'h00;
    out_ready    = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
